// File: rtl/divider32_pkg.sv
// Shared types and constants for the divider32 restoring divider.
package divider32_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider32_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit,
// subtract the divisor when it fits.
module div_step
    import divider32_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] divisor,
    input  logic            dbit,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] diff;
    logic            borrow;

    assign rem_shift = {rem, dbit};

    // rem_shift < 2*divisor, so bit XLEN of the 33-bit difference is exactly the borrow.
    assign {borrow, diff} = rem_shift - {1'b0, divisor};

    assign q_bit    = ~borrow;
    assign rem_next = q_bit ? diff : rem_shift[XLEN-1:0];

endmodule

// File: rtl/divider32.sv
// RV32M DIV/DIVU/REM/REMU multi-cycle divider with valid/ready handshakes.
// Optional build macro DIVIDER32_FASTPATH_EN: divide-by-zero and signed overflow skip CALC.
module divider32
    import divider32_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y
);

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    div_op_t          op_reg;
    logic [XLEN-1:0]  a_reg, b_reg, dvd_reg, dvs_reg, rem_reg, y_reg;
    logic             neg_q_reg, neg_r_reg, out_valid_reg;

    logic             op_signed, in_special;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN-1:0]  rem_next;
    logic             q_bit;
    logic             reg_signed, b_zero, sovf;
    logic [XLEN-1:0]  quo_fix, rem_fix, quo_res, rem_res, result;

    assign op_signed  = (op == DIV) || (op == REM);
    assign abs_a      = (op_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
    assign abs_b      = (op_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
    assign in_special = (b == '0) || (op_signed && a == INT_MIN && b == ALL_ONES);

    div_step u_step (
        .rem      (rem_reg),
        .divisor  (dvs_reg),
        .dbit     (dvd_reg[XLEN-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Special cases override the magnitude result, so both builds agree.
    assign reg_signed = (op_reg == DIV) || (op_reg == REM);
    assign b_zero     = (b_reg == '0);
    assign sovf       = reg_signed && a_reg == INT_MIN && b_reg == ALL_ONES;
    assign quo_fix    = neg_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
    assign rem_fix    = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

    always_comb begin
        quo_res = quo_fix;
        rem_res = rem_fix;
        if (b_zero) begin
            quo_res = ALL_ONES;
            rem_res = a_reg;
        end else if (sovf) begin
            quo_res = INT_MIN;
            rem_res = '0;
        end
        result = ((op_reg == REM) || (op_reg == REMU)) ? rem_res : quo_res;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
`ifdef DIVIDER32_FASTPATH_EN
                    state_next = in_special ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt_reg == CNT_W'(XLEN - 1))
                    state_next = DONE;
            end
            DONE: begin
                if (out_valid_reg && out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            op_reg        <= DIV;
            a_reg         <= '0;
            b_reg         <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        cnt_reg   <= '0;
                        op_reg    <= div_op_t'(op);
                        a_reg     <= a;
                        b_reg     <= b;
                        dvd_reg   <= abs_a;
                        dvs_reg   <= abs_b;
                        rem_reg   <= '0;
                        neg_q_reg <= op_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r_reg <= op_signed && a[XLEN-1];
                    end
                end
                CALC: begin
                    // Quotient bits fill the dividend register from the bottom as it shifts out.
                    rem_reg <= rem_next;
                    dvd_reg <= {dvd_reg[XLEN-2:0], q_bit};
                    cnt_reg <= cnt_reg + 1'b1;
                end
                DONE: begin
                    if (!out_valid_reg) begin
                        y_reg         <= result;
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign y         = y_reg;

endmodule

// File: tb/tb_divider32.sv
// Self-checking bench for divider32: vector table with a scoreboard queue,
// plus hand sequences for output stall, ignored requests and mid-calculation reset.
module tb_divider32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

`ifdef DIVIDER32_FASTPATH_EN
    localparam int SLAT = 1;
`else
    localparam int SLAT = 33;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    divider32 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Runs one request to completion; called at posedge+1 with the divider idle.
    task automatic run_txn(input string name, input logic [1:0] t_op, input logic [31:0] t_a,
                           input logic [31:0] t_b, input logic [31:0] t_y, input int t_lat,
                           input int t_hold, input bit t_pulse);
        int          cyc;
        logic [31:0] exp_y;
        logic [31:0] y_seen;
        chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(t_y);
        in_valid = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        cyc = 0;
        do begin
            if (t_pulse && cyc >= 5 && cyc < 8) begin
                in_valid = 1'b1;
                chk({name, "_busy_in_ready"}, {31'b0, in_ready}, 32'd0);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 200);
        in_valid = 1'b0;
        chk({name, "_latency"}, 32'(cyc), 32'(t_lat));
        if (exp_q.size() == 0) begin
            chk({name, "_queue"}, 32'd0, 32'd1);
            exp_y = 'x;
        end else begin
            exp_y = exp_q.pop_front();
        end
        chk({name, "_y"}, y, exp_y);
        $display("txn %s op=%0d a=%h b=%h y=%h exp=%h lat=%0d", name, t_op, t_a, t_b, y, exp_y, cyc);
        y_seen = y;
        for (int i = 0; i < t_hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            chk({name, "_hold_y"}, y, y_seen);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_post_valid"}, {31'b0, out_valid}, 32'd0);
        chk({name, "_post_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int spurious;
        vecs.push_back(vec_t'{2'd1, 32'd100,        32'd7,        32'd14,        33});
        vecs.push_back(vec_t'{2'd3, 32'd100,        32'd7,        32'd2,         33});
        vecs.push_back(vec_t'{2'd0, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  33});
        vecs.push_back(vec_t'{2'd2, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF,  33});
        vecs.push_back(vec_t'{2'd0, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  33});
        vecs.push_back(vec_t'{2'd2, 32'd7,          32'hFFFFFFFE, 32'd1,         33});
        vecs.push_back(vec_t'{2'd0, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,         33});
        vecs.push_back(vec_t'{2'd2, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF,  33});
        vecs.push_back(vec_t'{2'd0, 32'h12345678,   32'd0,        32'hFFFFFFFF,  SLAT});
        vecs.push_back(vec_t'{2'd1, 32'h12345678,   32'd0,        32'hFFFFFFFF,  SLAT});
        vecs.push_back(vec_t'{2'd2, 32'h12345678,   32'd0,        32'h12345678,  SLAT});
        vecs.push_back(vec_t'{2'd3, 32'h12345678,   32'd0,        32'h12345678,  SLAT});
        vecs.push_back(vec_t'{2'd0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  SLAT});
        vecs.push_back(vec_t'{2'd2, 32'h80000000,   32'hFFFFFFFF, 32'd0,         SLAT});
        vecs.push_back(vec_t'{2'd1, 32'h80000000,   32'hFFFFFFFF, 32'd0,         33});
        vecs.push_back(vec_t'{2'd3, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  33});
        vecs.push_back(vec_t'{2'd1, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  33});
        vecs.push_back(vec_t'{2'd1, 32'hFFFFFFFF,   32'h00010000, 32'h0000FFFF,  33});
        vecs.push_back(vec_t'{2'd3, 32'hFFFFFFFF,   32'h00010000, 32'h0000FFFF,  33});
        vecs.push_back(vec_t'{2'd0, 32'h80000000,   32'd2,        32'hC0000000,  33});
        vecs.push_back(vec_t'{2'd0, 32'h80000000,   32'd3,        32'hD5555556,  33});
        vecs.push_back(vec_t'{2'd2, 32'h80000000,   32'd3,        32'hFFFFFFFE,  33});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_y", y, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_txn($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y,
                    vecs[i].lat, 0, 1'b0);

        run_txn("stall", 2'd1, 32'd100, 32'd7, 32'd14, 33, 10, 1'b0);
        run_txn("busy_pulse", 2'd1, 32'd200, 32'd10, 32'd20, 33, 0, 1'b1);

        // Mid-calculation reset discards the pending 1000/3.
        op = 2'd1; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("midcalc_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        chk("rst_no_stale_result", 32'(spurious), 32'd0);
        run_txn("after_reset", 2'd1, 32'd50, 32'd5, 32'd10, 33, 0, 1'b0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
